zap_fifo_reader: RTL and testbench
==================================

ZAP_FIFO_READER -- requirements
Module: zap_fifo_reader

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter CNT_WDT, default 16, width of delivered-word counter.
REQ-003 i_clk  input  1  core clock; all state updates on rising edge.
REQ-004 i_reset_n  input  1  asynchronous active-low reset.
REQ-005 i_clear  input  1  synchronous flush of buffered and in-flight data.
REQ-006 i_fifo_empty_n  input  1  source FIFO holds at least one word (registered flag from FIFO).
REQ-007 o_fifo_ack  output  1  read request to non-FWFT source FIFO; word returns on i_fifo_data one cycle later.
REQ-008 i_fifo_data  input  WIDTH  FIFO read data, valid the cycle after an accepted ack.
REQ-009 o_valid  output  1  output word available.
REQ-010 i_ready  input  1  downstream accepts word.
REQ-011 o_data  output  WIDTH  output word.
REQ-012 o_idle  output  1  no buffered and no in-flight words.
REQ-013 o_words  output  CNT_WDT  count of words delivered (o_valid && i_ready).

Function
REQ-014 Block SHALL contain a 2-entry circular skid buffer: 1-bit write pointer, 1-bit read pointer, 2-bit occupancy occ (0..2).
REQ-015 Block SHALL hold 1-bit inflight flag = registered value of o_fifo_ack (cleared by i_clear).
REQ-016 pop = o_valid && i_ready; o_fifo_ack SHALL equal i_fifo_empty_n && !i_clear && (occ + inflight - pop) <= 1 (combinational, 3-bit arithmetic, no underflow since pop implies occ >= 1).
REQ-017 When inflight = 1 and i_clear = 0, i_fifo_data SHALL be written to buffer[wptr] at the clock edge, wptr toggles, occ increments.
REQ-018 On pop, rptr SHALL toggle and occ decrement; simultaneous write and pop SHALL leave occ unchanged.
REQ-019 o_valid SHALL equal (occ != 0); o_data SHALL equal buffer[rptr] (registered storage, mux output).
REQ-020 While o_valid = 1 and i_ready = 0, o_data and o_valid SHALL remain stable.
REQ-021 occ SHALL never exceed 2; no returned word SHALL ever be dropped outside i_clear.
REQ-022 Latency: ack in cycle N -> word captured at end of cycle N+1 -> o_valid in cycle N+2 (when buffer was empty).
REQ-023 Throughput: with i_fifo_empty_n and i_ready held high, steady state SHALL deliver one word per cycle.
REQ-024 i_clear = 1 in cycle C: ack suppressed in C; at C edge occ, inflight, wptr, rptr SHALL go to 0; word returning during C SHALL be discarded; o_valid = 0 in C+1.
REQ-025 i_clear SHALL NOT count a pop in cycle C for o_words even if i_ready = 1; o_valid is still driven in C but the word is discarded.
REQ-026 o_words SHALL increment by 1 per pop, wrapping modulo 2^CNT_WDT; unaffected by i_clear.
REQ-027 o_idle SHALL equal (occ == 0) && !inflight.
REQ-028 i_fifo_empty_n deasserting SHALL stop new acks the same cycle; in-flight word still captured.

Reset
REQ-029 Assertion of i_reset_n low SHALL immediately force occ = 0, inflight = 0, wptr = rptr = 0, o_words = 0, independent of i_clk.
REQ-030 During and after reset until first edge: o_valid = 0, o_fifo_ack = i_fifo_empty_n, o_idle = 1; buffer contents need no reset.
REQ-031 Reset mid-transfer SHALL discard buffered and in-flight words; no word from before reset SHALL appear on o_data.

Verification
REQ-032 Single word: empty_n high one cycle with data 0xA5A5_0001, i_ready = 1 -> ack cycle 0, o_valid cycle 2 with 0xA5A5_0001, o_words = 1, o_idle = 1 in cycle 3.
REQ-033 Streaming: FIFO preloaded 0..15, i_ready = 1 -> words 0..15 in order on consecutive cycles 2..17, o_words = 16.
REQ-034 Backpressure: i_ready = 0 for 10 cycles with 8 words available -> at most 2 acks issued, occ = 2, o_data = word 0 stable; release -> remaining words in order, none lost or duplicated.
REQ-035 Clear with ack in flight: ack cycle 0, i_clear cycle 1 -> word discarded, o_valid = 0 cycle 2, o_idle = 1 cycle 2; next ack resumes with following FIFO word.
REQ-036 Async reset asserted mid-cycle with occ = 2 -> o_valid = 0 before next edge; o_words = 0.
REQ-037 Counter wrap: CNT_WDT = 4, deliver 17 words -> o_words = 1; random ready/empty_n soak against scoreboard with zero mismatches.

Source files
------------

// File: rtl/zap_fifo_reader.sv
// zap_fifo_reader: drains a non-FWFT FIFO into a valid/ready stream through a 2-entry skid buffer,
// counting delivered words.
module zap_fifo_reader #(
    parameter int WIDTH   = 32,
    parameter int CNT_WDT = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clear,
    input  logic               i_fifo_empty_n,
    output logic               o_fifo_ack,
    input  logic [WIDTH-1:0]   i_fifo_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_idle,
    output logic [CNT_WDT-1:0] o_words
);
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q, inflight_d;
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [CNT_WDT-1:0] words_q, words_d;
    logic [WIDTH-1:0]   buf_q [2];
    logic               pop, wr;
    logic [2:0]         level;

    always_comb begin
        pop        = o_valid && i_ready;
        wr         = inflight_q && !i_clear;
        // Occupancy after this cycle's pop, counting the word already requested.
        level      = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
        o_fifo_ack = i_fifo_empty_n && !i_clear && (level <= 3'd1);
        inflight_d = o_fifo_ack;
        occ_d      = i_clear ? 2'd0 : occ_q + {1'b0, wr} - {1'b0, pop};
        wptr_d     = !i_clear && (wptr_q ^ wr);
        rptr_d     = !i_clear && (rptr_q ^ pop);
        words_d    = words_q + {{(CNT_WDT-1){1'b0}}, pop && !i_clear};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            words_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            words_q    <= words_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr) buf_q[wptr_q] <= i_fifo_data;
    end

    assign o_valid = occ_q != 2'd0;
    assign o_data  = buf_q[rptr_q];
    assign o_idle  = (occ_q == 2'd0) && !inflight_q;
    assign o_words = words_q;
endmodule

// File: tb/tb_zap_fifo_reader.sv
// tb_zap_fifo_reader: directed scenarios with a FIFO source model and an expected-word scoreboard.
module tb_zap_fifo_reader;
    logic        clk = 0, rst_n = 0, clear = 0, en = 0, ready = 0;
    logic [31:0] fdata = '0;
    logic        empty_n, ack, valid, idle, ack_w, valid_w, idle_w;
    logic [31:0] data, data_w;
    logic [15:0] words;
    logic [3:0]  words_w;
    logic [31:0] mem [0:1023];
    int          wr_idx = 0, rd_idx = 0, n_pop = 0, pass_cnt = 0, tot_cnt = 0;
    logic [31:0] exp_q [$];

    zap_fifo_reader dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear), .i_fifo_empty_n(empty_n),
        .o_fifo_ack(ack), .i_fifo_data(fdata), .o_valid(valid), .i_ready(ready),
        .o_data(data), .o_idle(idle), .o_words(words)
    );

    zap_fifo_reader #(.WIDTH(32), .CNT_WDT(4)) u_wrap (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear), .i_fifo_empty_n(empty_n),
        .o_fifo_ack(ack_w), .i_fifo_data(fdata), .o_valid(valid_w), .i_ready(ready),
        .o_data(data_w), .o_idle(idle_w), .o_words(words_w)
    );

    always #5 clk = ~clk;

    assign empty_n = en && (rd_idx < wr_idx);

    // Non-FWFT source: an acked word appears on the data bus after the edge.
    always @(posedge clk) begin
        if (ack) begin
            fdata  <= mem[rd_idx];
            rd_idx <= rd_idx + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && valid && ready && !clear) begin
            n_pop++;
            if (exp_q.size() == 0) check("sb_extra_word", exp_q.size(), 1);
            else check("sb_data", data, exp_q.pop_front());
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] w, input bit expect_out);
        mem[wr_idx] = w;
        wr_idx++;
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cyc();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int base, r0, n;
        repeat (2) cyc();
        rst_n = 1;
        cyc(); #1;
        check("rst_valid", valid, 0);
        check("rst_idle", idle, 1);
        check("rst_words", words, 0);
        check("rst_ack", ack, empty_n);
        // single word
        load(32'hA5A5_0001, 1);
        cyc(); en = 1; ready = 1; #1;
        check("sw_ack_c0", ack, 1);
        cyc(); #1;
        check("sw_valid_c1", valid, 0);
        check("sw_ack_c1", ack, 0);
        cyc(); #1;
        check("sw_valid_c2", valid, 1);
        check("sw_data_c2", data, 32'hA5A5_0001);
        cyc(); #1;
        check("sw_idle_c3", idle, 1);
        check("sw_words_c3", words, 1);
        // streaming
        en = 0;
        for (int i = 0; i < 16; i++) load(i, 1);
        base = words;
        for (int k = 0; k < 18; k++) begin
            cyc();
            en = 1;
            #1;
            check($sformatf("st_valid_c%0d", k), valid, k >= 2);
        end
        cyc(); #1;
        check("st_words", words, base + 16);
        // backpressure
        cyc(); en = 0; ready = 0;
        for (int i = 0; i < 8; i++) load(32'hB000_0000 + i, 1);
        r0 = rd_idx;
        for (int k = 0; k < 10; k++) begin
            cyc();
            en = 1;
            #1;
            if (k >= 2) begin
                check("bp_valid", valid, 1);
                check("bp_data", data, 32'hB000_0000);
            end
        end
        check("bp_acks", rd_idx - r0, 2);
        check("bp_ack_held", ack, 0);
        ready = 1;
        drain("bp_drain");
        // clear with an ack in flight
        cyc(); en = 0;
        load(32'hC000_0000, 0);
        load(32'hC000_0001, 1);
        cyc(); en = 1; #1;
        check("clr_ack_c0", ack, 1);
        cyc(); clear = 1; #1;
        check("clr_ack_c1", ack, 0);
        cyc(); clear = 0; #1;
        check("clr_valid_c2", valid, 0);
        check("clr_idle_c2", idle, 1);
        check("clr_ack_c2", ack, 1);
        drain("clr_drain");
        // clear while a word is presented
        cyc(); en = 0; ready = 0;
        load(32'hD000_0000, 0);
        cyc(); en = 1;
        repeat (3) cyc();
        #1 check("clrv_valid_before", valid, 1);
        base = words;
        cyc(); clear = 1; ready = 1; #1;
        check("clrv_valid_driven", valid, 1);
        cyc(); clear = 0; ready = 0; #1;
        check("clrv_valid_after", valid, 0);
        check("clrv_words", words, base);
        // random soak
        cyc(); en = 0;
        for (int i = 0; i < 40; i++) load($urandom, 1);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            cyc();
            en = 1'($urandom_range(0, 1));
            ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("soak_drain", exp_q.size(), 0);
        cyc(); ready = 0; en = 0; #1;
        check("words_total", words, n_pop);
        check("wrap_words", words_w, n_pop % 16);
        // async reset with a full buffer
        load(32'hE000_0000, 0);
        load(32'hE000_0001, 0);
        load(32'hE000_0002, 0);
        cyc(); en = 1;
        repeat (4) cyc();
        #1;
        check("ar_valid_full", valid, 1);
        check("ar_ack_full", ack, 0);
        #1 rst_n = 0;
        #1;
        check("ar_valid", valid, 0);
        check("ar_words", words, 0);
        check("ar_words_wrap", words_w, 0);
        check("ar_idle", idle, 1);
        check("ar_ack", ack, empty_n);
        cyc(); en = 0; wr_idx = rd_idx;
        cyc(); rst_n = 1; ready = 1;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            check("ar_no_stale", valid, 0);
        end
        check("sb_final_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
